button_position_counter: RTL and testbench

Upstream stage of the rotating-message display path. It debounces a raw push-button, detects presses, and advances a 4-bit rotation position (0–15, wrapping). Holding the button auto-repeats the advance. The `counter` output feeds the character-window memory stage, which maps the position to the four anode characters.

---
 rtl/rotation_pkg.sv | 25 ++
 rtl/button_position_counter_if.sv | 14 +
 rtl/button_debouncer.sv | 54 +++++
 rtl/button_position_counter.sv | 107 ++++++++++
 tb/tb_button_position_counter.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rotation_pkg.sv
// Shared types and constants for the rotating-message display path.
// Holds the button FSM state type, the rotation position width and the
// default timing constants (50 MHz clock).
package rotation_pkg;

    // Rotation position width, shared with the character-window stage.
    localparam int unsigned POS_W = 4;

    // Default timing: 10 ms debounce, 0.5 s to first repeat, 0.25 s repeat period.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 12500000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } btn_state_e;

    // Larger of two unsigned values, used to size the shared repeat timer.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_position_counter_if.sv
// Button-to-position bus between the button source and the position counter.
//   button     : raw push-button level (high = pressed), driven by the master
//   counter    : current rotation position, driven by the slave
//   step_pulse : one-cycle strobe following each position update, driven by the slave
interface button_position_counter_if;
    import rotation_pkg::*;

    logic             button;
    logic [POS_W-1:0] counter;
    logic             step_pulse;

    modport master (output button, input counter, input step_pulse);
    modport slave  (input button, output counter, output step_pulse);
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a debounce counter for a raw push-button.
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   button : raw asynchronous button level
//   stable : debounced level, flips only after DEBOUNCE_CYCLES consecutive mismatches
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = rotation_pkg::DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic stable
);
    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] deb_cnt_q;
    logic [CNT_W-1:0] deb_cnt_d;

    // Synchronizer, debounced level and mismatch counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= button;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Any agreeing cycle restarts the count, so short glitches never flip the level.
    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = '0;
        if (sync2_q != stable_q) begin
            if (deb_cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/button_position_counter.sv
// Debounced push-button driven rotation position counter with auto-repeat.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; aborts any press or repeat in progress
//   bus   : slave side of button_position_counter_if
//           (button in; counter and step_pulse out, both registered)
module button_position_counter
    import rotation_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input logic                      clk,
    input logic                      reset,
    button_position_counter_if.slave bus
);
    localparam int unsigned        TIMER_W    = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [TIMER_W-1:0] DELAY_LAST = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] PERIOD_LAST = TIMER_W'(REPEAT_PERIOD - 1);
    localparam bit                 REPEAT_EN  = (REPEAT_DELAY != 0);

    logic stable;

    btn_state_e       state_q;
    btn_state_e       state_d;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;
    logic [POS_W-1:0] counter_q;
    logic [POS_W-1:0] counter_d;
    logic             step_pulse_q;
    logic             step_pulse_d;
    logic             do_step;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk   (clk),
        .reset (reset),
        .button(bus.button),
        .stable(stable)
    );

    // State, timer and position registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            counter_q    <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            counter_q    <= counter_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    // Next state, step decision and position update.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        do_step = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (stable) begin
                    do_step = 1'b1;
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                timer_d = timer_q + TIMER_W'(1);
                if (REPEAT_EN && (timer_q == DELAY_LAST)) begin
                    do_step = 1'b1;
                    state_d = REPEAT;
                    timer_d = '0;
                end
            end
            REPEAT: begin
                timer_d = timer_q + TIMER_W'(1);
                if (timer_q == PERIOD_LAST) begin
                    do_step = 1'b1;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        // Release wins over a repeat step falling due in the same cycle.
        if (!stable) begin
            state_d = IDLE;
            timer_d = '0;
            do_step = 1'b0;
        end

        counter_d    = do_step ? (counter_q + POS_W'(1)) : counter_q;
        step_pulse_d = do_step;
    end

    assign bus.counter    = counter_q;
    assign bus.step_pulse = step_pulse_q;

endmodule

// File: tb/tb_button_position_counter.sv
// Self-checking bench for button_position_counter with short timing parameters.
module tb_button_position_counter;
    import rotation_pkg::*;

    localparam int D  = 4;
    localparam int RD = 8;
    localparam int RP = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    button_position_counter_if bus ();

    button_position_counter #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int exp_pos = 0;
    bit lvl_q[$];
    bit exp_step[$];

    function automatic void push_run(input bit v, input int len);
        for (int k = 0; k < len; k++) lvl_q.push_back(v);
    endfunction

    // Reference model for clean input (every run at least D samples long):
    // a high run starting at sample edge s of length L is seen as held on
    // edges s+D+2 .. s+L+D+1; the first step lands on the first of those,
    // then RD later, then every RP while still held.
    function automatic void model_steps();
        int n;
        int i;
        int s;
        int len;
        int first;
        int last;
        int e;
        n = lvl_q.size();
        i = 0;
        exp_step.delete();
        for (int k = 0; k < n; k++) exp_step.push_back(1'b0);
        while (i < n) begin
            if (lvl_q[i]) begin
                s   = i + 1;
                len = 0;
                while (i < n && lvl_q[i]) begin
                    len++;
                    i++;
                end
                first = s + D + 2;
                last  = s + len + D + 1;
                if (first <= n) exp_step[first-1] = 1'b1;
                if (RD != 0) begin
                    e = first + RD;
                    while (e <= last) begin
                        if (e <= n) exp_step[e-1] = 1'b1;
                        e += RP;
                    end
                end
            end else begin
                i++;
            end
        end
    endfunction

    task automatic apply_reset();
        bus.button = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_pos = 0;
    endtask

    task automatic test_reset();
        bus.button = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (bus.counter !== 4'd0 || bus.step_pulse !== 1'b0)
            $display("FAIL reset_state: counter=%0d pulse=%0b, want 0/0", bus.counter, bus.step_pulse);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        exp_pos = 0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            n_total++;
            if (bus.counter !== 4'd0 || bus.step_pulse !== 1'b0)
                $display("FAIL reset_idle edge %0d: counter=%0d pulse=%0b, want 0/0", e, bus.counter, bus.step_pulse);
            else n_pass++;
        end
    endtask

    task automatic test_clean_press();
        int first_edge;
        int pulses;
        apply_reset();
        lvl_q.delete();
        push_run(1'b1, 6);
        push_run(1'b0, 14);
        model_steps();
        first_edge = -1;
        pulses = 0;
        for (int e = 1; e <= lvl_q.size(); e++) begin
            bus.button = lvl_q[e-1];
            @(posedge clk); #1;
            if (exp_step[e-1]) exp_pos = (exp_pos + 1) % 16;
            if (bus.step_pulse === 1'b1) begin
                pulses++;
                if (first_edge < 0) first_edge = e;
            end
            n_total++;
            if (bus.counter !== 4'(exp_pos) || bus.step_pulse !== exp_step[e-1])
                $display("FAIL clean_press edge %0d: counter=%0d pulse=%0b, want %0d/%0b",
                         e, bus.counter, bus.step_pulse, exp_pos, exp_step[e-1]);
            else n_pass++;
        end
        n_total++;
        if (first_edge !== 7 || pulses !== 1 || bus.counter !== 4'd1)
            $display("FAIL clean_press_summary: first_edge=%0d pulses=%0d counter=%0d, want 7/1/1",
                     first_edge, pulses, bus.counter);
        else n_pass++;
    endtask

    task automatic test_bounce();
        int pulses;
        apply_reset();
        pulses = 0;
        for (int e = 1; e <= 32; e++) begin
            bus.button = (e <= 20) ? (((e - 1) / 2) % 2 == 0) : 1'b0;
            @(posedge clk); #1;
            if (bus.step_pulse === 1'b1) pulses++;
            n_total++;
            if (bus.counter !== 4'd0 || bus.step_pulse !== 1'b0)
                $display("FAIL bounce edge %0d: counter=%0d pulse=%0b, want 0/0", e, bus.counter, bus.step_pulse);
            else n_pass++;
        end
        n_total++;
        if (pulses !== 0)
            $display("FAIL bounce_pulses: pulses=%0d, want 0", pulses);
        else n_pass++;
    endtask

    task automatic test_hold_repeat();
        int edges[$];
        apply_reset();
        lvl_q.delete();
        push_run(1'b1, 27);
        push_run(1'b0, 20);
        model_steps();
        for (int e = 1; e <= lvl_q.size(); e++) begin
            bus.button = lvl_q[e-1];
            @(posedge clk); #1;
            if (exp_step[e-1]) exp_pos = (exp_pos + 1) % 16;
            if (bus.step_pulse === 1'b1) edges.push_back(e);
            n_total++;
            if (bus.counter !== 4'(exp_pos) || bus.step_pulse !== exp_step[e-1])
                $display("FAIL hold_repeat edge %0d: counter=%0d pulse=%0b, want %0d/%0b",
                         e, bus.counter, bus.step_pulse, exp_pos, exp_step[e-1]);
            else n_pass++;
        end
        n_total++;
        if (edges.size() != 6 || edges[0] != 7 || edges[1] != 15 || edges[2] != 19 ||
            edges[3] != 23 || edges[4] != 27 || edges[5] != 31 || bus.counter !== 4'd6)
            $display("FAIL hold_repeat_summary: steps=%0d counter=%0d, want steps at 7,15,19,23,27,31 and counter 6",
                     edges.size(), bus.counter);
        else n_pass++;
    endtask

    task automatic test_release_on_repeat();
        int edges[$];
        apply_reset();
        lvl_q.delete();
        push_run(1'b1, 12);
        push_run(1'b0, 20);
        model_steps();
        for (int e = 1; e <= lvl_q.size(); e++) begin
            bus.button = lvl_q[e-1];
            @(posedge clk); #1;
            if (exp_step[e-1]) exp_pos = (exp_pos + 1) % 16;
            if (bus.step_pulse === 1'b1) edges.push_back(e);
            n_total++;
            if (bus.counter !== 4'(exp_pos) || bus.step_pulse !== exp_step[e-1])
                $display("FAIL release_on_repeat edge %0d: counter=%0d pulse=%0b, want %0d/%0b",
                         e, bus.counter, bus.step_pulse, exp_pos, exp_step[e-1]);
            else n_pass++;
        end
        n_total++;
        if (edges.size() != 2 || edges[0] != 7 || edges[1] != 15 || bus.counter !== 4'd2)
            $display("FAIL release_on_repeat_summary: steps=%0d counter=%0d, want steps at 7,15 only and counter 2",
                     edges.size(), bus.counter);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int vals[$];
        apply_reset();
        lvl_q.delete();
        for (int p = 0; p < 17; p++) begin
            push_run(1'b1, 6);
            push_run(1'b0, 6);
        end
        push_run(1'b0, 10);
        model_steps();
        for (int e = 1; e <= lvl_q.size(); e++) begin
            bus.button = lvl_q[e-1];
            @(posedge clk); #1;
            if (exp_step[e-1]) exp_pos = (exp_pos + 1) % 16;
            if (bus.step_pulse === 1'b1) vals.push_back(int'(bus.counter));
            n_total++;
            if (bus.counter !== 4'(exp_pos) || bus.step_pulse !== exp_step[e-1])
                $display("FAIL wrap edge %0d: counter=%0d pulse=%0b, want %0d/%0b",
                         e, bus.counter, bus.step_pulse, exp_pos, exp_step[e-1]);
            else n_pass++;
        end
        n_total++;
        if (vals.size() != 17 || vals[13] != 14 || vals[14] != 15 || vals[15] != 0 || vals[16] != 1)
            $display("FAIL wrap_sequence: pulses=%0d, want 17 pulses ending 14,15,0,1", vals.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_repeat();
        apply_reset();
        lvl_q.delete();
        push_run(1'b1, 28);
        model_steps();
        for (int e = 1; e <= lvl_q.size(); e++) begin
            bus.button = lvl_q[e-1];
            @(posedge clk); #1;
            if (exp_step[e-1]) exp_pos = (exp_pos + 1) % 16;
            n_total++;
            if (bus.counter !== 4'(exp_pos) || bus.step_pulse !== exp_step[e-1])
                $display("FAIL mid_repeat_hold edge %0d: counter=%0d pulse=%0b, want %0d/%0b",
                         e, bus.counter, bus.step_pulse, exp_pos, exp_step[e-1]);
            else n_pass++;
        end
        n_total++;
        if (bus.counter !== 4'd5)
            $display("FAIL mid_repeat_pre: counter=%0d, want 5", bus.counter);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_total++;
        if (bus.counter !== 4'd0 || bus.step_pulse !== 1'b0)
            $display("FAIL async_reset: counter=%0d pulse=%0b, want 0/0", bus.counter, bus.step_pulse);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (bus.counter !== 4'd0 || bus.step_pulse !== 1'b0)
            $display("FAIL reset_held: counter=%0d pulse=%0b, want 0/0", bus.counter, bus.step_pulse);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        exp_pos = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            n_total++;
            if (bus.counter !== ((e >= 7) ? 4'd1 : 4'd0) || bus.step_pulse !== (e == 7))
                $display("FAIL held_through_reset edge %0d: counter=%0d pulse=%0b, want %0d/%0b",
                         e, bus.counter, bus.step_pulse, (e >= 7) ? 1 : 0, (e == 7));
            else n_pass++;
            if (e == 8) bus.button = 1'b0;
        end
        exp_pos = 1;
    endtask

    task automatic test_random();
        lvl_q.delete();
        for (int p = 0; p < 8; p++) begin
            push_run(1'b1, int'($urandom_range(30, D)));
            push_run(1'b0, int'($urandom_range(12, D)));
        end
        push_run(1'b0, 10);
        model_steps();
        for (int e = 1; e <= lvl_q.size(); e++) begin
            bus.button = lvl_q[e-1];
            @(posedge clk); #1;
            if (exp_step[e-1]) exp_pos = (exp_pos + 1) % 16;
            n_total++;
            if (bus.counter !== 4'(exp_pos) || bus.step_pulse !== exp_step[e-1])
                $display("FAIL random edge %0d: counter=%0d pulse=%0b, want %0d/%0b",
                         e, bus.counter, bus.step_pulse, exp_pos, exp_step[e-1]);
            else n_pass++;
        end
    endtask

    initial begin
        bus.button = 1'b0;
        reset = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold_repeat();
        test_release_on_repeat();
        test_wrap();
        test_reset_mid_repeat();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
